// File: rtl/icache_miss_sched_pkg.sv
// Shared frontend definitions: L2 op encodings, line geometry, miss FSM states.
package icache_miss_sched_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_R   = 3'b001;

    localparam int LINE_BITS_DEF = 6;
    localparam int LINE_W        = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Candidate prefetch hint after priority selection
    typedef struct packed {
        logic        vld;
        logic [31:0] addr;
    } pf_req_t;

    // Zero the byte-offset bits so every address names a whole line
    function automatic logic [31:0] line_align(input logic [31:0] a, input int unsigned lb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << lb;
        return a & m;
    endfunction

endpackage

// File: rtl/icache_miss_sched_pf_fifo.sv
// Prefetch hint FIFO with flush and an associative match port for dedup.
module icache_miss_sched_pf_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic          pop,
    input  logic          flush,
    input  logic [AW-1:0] match_addr,
    output logic [AW-1:0] head_addr,
    output logic          full,
    output logic          empty,
    output logic          match
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [DEPTH-1:0][AW-1:0] mem;
    logic [DEPTH-1:0]         vld;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [PW:0]              count;
    logic                     do_push;
    logic                     do_pop;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign head_addr = mem[rd_ptr];
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept
    assign do_push   = push && (!full || do_pop);

    // Dedup lookup across all live entries
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i] && mem[i] == match_addr) match = 1'b1;
    end

    // Storage, valid bits and pointers; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Clear before set: when full, push and pop share one slot
            if (do_pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                mem[wr_ptr] <= push_addr;
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/icache_miss_sched.sv
// Icache miss scheduler: one outstanding L2 line read, demand over prefetch.
module icache_miss_sched
    import icache_miss_sched_pkg::*;
#(
    parameter int PF_DEPTH  = 4,
    parameter int LINE_BITS = LINE_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmd_valid,
    input  logic [31:0]       dmd_paddr,
    output logic              dmd_ready,
    input  logic              bppf_valid,
    input  logic [31:0]       bppf_paddr,
    input  logic              nlpf_valid,
    input  logic [31:0]       nlpf_paddr,
    input  logic              prefetch_valid,
    input  logic [31:0]       prefetch_addr,
    input  logic              resteer,
    output logic [2:0]        icache_l2_op,
    output logic [31:0]       icache_l2_addr,
    input  logic [2:0]        l2_icache_op,
    input  logic [31:0]       l2_icache_addr,
    input  logic [LINE_W-1:0] l2_icache_data,
    output logic              fill_valid,
    output logic [31:0]       fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              fill_demand,
    output logic              busy
);
    state_t      state_q, state_d;
    logic [31:0] inf_addr_q, inf_addr_d;
    logic        inf_dmd_q, inf_dmd_d;
    logic        dmd_ready_d;
    logic        fill_d;

    logic [31:0] dmd_line;
    logic [31:0] rsp_line;
    pf_req_t     pf_cand;

    logic        pf_push, pf_pop;
    logic [31:0] pf_head;
    logic        pf_full, pf_empty, pf_match;

    assign dmd_line = line_align(dmd_paddr, LINE_BITS);
    assign rsp_line = line_align(l2_icache_addr, LINE_BITS);

    // Highest-priority source wins; lower ones in the same cycle are dropped
    always_comb begin
        pf_cand = '0;
        if (bppf_valid)          pf_cand = '{vld: 1'b1, addr: line_align(bppf_paddr, LINE_BITS)};
        else if (nlpf_valid)     pf_cand = '{vld: 1'b1, addr: line_align(nlpf_paddr, LINE_BITS)};
        else if (prefetch_valid) pf_cand = '{vld: 1'b1, addr: line_align(prefetch_addr, LINE_BITS)};
    end

    // Enqueue unless flushing, full without a freeing pop, or redundant
    assign pf_push = pf_cand.vld && !resteer && (!pf_full || pf_pop) && !pf_match &&
                     !((state_q != IDLE) && pf_cand.addr == inf_addr_q);

    icache_miss_sched_pf_fifo #(
        .DEPTH (PF_DEPTH),
        .AW    (32)
    ) u_pf_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (pf_push),
        .push_addr  (pf_cand.addr),
        .pop        (pf_pop),
        .flush      (resteer),
        .match_addr (pf_cand.addr),
        .head_addr  (pf_head),
        .full       (pf_full),
        .empty      (pf_empty),
        .match      (pf_match)
    );

    // Next state, in-flight tracking, demand accept/merge and fill detection.
    // dmd_ready still high means the requester has not yet dropped the demand
    // it was just granted, so it must not be taken a second time.
    always_comb begin
        state_d     = state_q;
        inf_addr_d  = inf_addr_q;
        inf_dmd_d   = inf_dmd_q;
        dmd_ready_d = 1'b0;
        fill_d      = 1'b0;
        pf_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!resteer) begin
                    if (dmd_valid && !dmd_ready) begin
                        inf_addr_d  = dmd_line;
                        inf_dmd_d   = 1'b1;
                        dmd_ready_d = 1'b1;
                        state_d     = ISSUE;
                    end else if (!pf_empty) begin
                        inf_addr_d = pf_head;
                        inf_dmd_d  = 1'b0;
                        pf_pop     = 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (l2_icache_op == OP_R && rsp_line == inf_addr_q) begin
                    fill_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A demand hitting the in-flight prefetch upgrades it instead of reissuing
        if ((state_q != IDLE) && dmd_valid && !dmd_ready && !inf_dmd_q && !resteer &&
            dmd_line == inf_addr_q) begin
            inf_dmd_d   = 1'b1;
            dmd_ready_d = 1'b1;
        end
        // Flush drops demand ownership; the line itself still fills
        if (resteer) inf_dmd_d = 1'b0;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            inf_addr_q     <= '0;
            inf_dmd_q      <= 1'b0;
            dmd_ready      <= 1'b0;
            icache_l2_op   <= OP_NOP;
            icache_l2_addr <= '0;
            fill_valid     <= 1'b0;
            fill_addr      <= '0;
            fill_data      <= '0;
            fill_demand    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q      <= state_d;
            inf_addr_q   <= inf_addr_d;
            inf_dmd_q    <= inf_dmd_d;
            dmd_ready    <= dmd_ready_d;
            icache_l2_op <= (state_d == ISSUE) ? OP_R : OP_NOP;
            if (state_d == ISSUE) icache_l2_addr <= inf_addr_d;
            fill_valid   <= fill_d;
            fill_demand  <= fill_d && inf_dmd_d;
            if (fill_d) begin
                fill_addr <= inf_addr_q;
                fill_data <= l2_icache_data;
            end
            busy <= (state_d != IDLE);
        end
    end

endmodule
